oq_regs_host_proc: RTL and testbench

Per-queue register-file processor sitting directly downstream of the output-queue host register interface. It holds the 32-bit per-queue statistics/control registers, executes host reads and writes handed over through the held-request handshake (`req_in_progress` / `result_ready`), and also services read-modify-write updates from the queue datapath. A single arbiter serialises the two sources so the storage sees one access at a time.

---
 rtl/oq_regs_host_proc.sv | 156 +++++++++++++++
 tb/tb_oq_regs_host_proc.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oq_regs_host_proc.sv
// rtl/oq_regs_host_proc.sv - per-queue register file serving host accesses and datapath read-modify-write updates
//
// Ports:
//   clk, reset_n                     single clock, asynchronous active-low reset
//   req_in_progress                  host request level, held until result_ready
//   reg_rd_wr_L_held                 1 = host read, 0 = host write
//   reg_data_held                    host write data
//   addr, q_addr                     host register index and queue index
//   result_ready                     one-cycle pulse, host access complete
//   reg_result                       read data or echoed write data, held after result_ready
//   dp_upd_req                       datapath update request level, held until dp_upd_ack
//   dp_upd_q, dp_upd_addr            datapath queue and register index
//   dp_upd_delta                     two's-complement value added to the register
//   dp_upd_ack                       one-cycle pulse, update committed

module oq_regs_host_proc #(
    parameter int NUM_OUTPUT_QUEUES = 8,
    parameter int NUM_OQ_WIDTH      = $clog2(NUM_OUTPUT_QUEUES),
    parameter int NUM_REGS_USED     = 19,
    parameter int ADDR_WIDTH        = $clog2(NUM_REGS_USED),
    parameter int DATA_WIDTH        = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req_in_progress,
    input  logic                    reg_rd_wr_L_held,
    input  logic [DATA_WIDTH-1:0]   reg_data_held,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [NUM_OQ_WIDTH-1:0] q_addr,
    output logic                    result_ready,
    output logic [DATA_WIDTH-1:0]   reg_result,
    input  logic                    dp_upd_req,
    input  logic [NUM_OQ_WIDTH-1:0] dp_upd_q,
    input  logic [ADDR_WIDTH-1:0]   dp_upd_addr,
    input  logic [DATA_WIDTH-1:0]   dp_upd_delta,
    output logic                    dp_upd_ack
);

    localparam int DEPTH = NUM_OUTPUT_QUEUES * NUM_REGS_USED;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic                    grant;
    logic                    grant_dp;
    logic                    prio_host;   // set after a datapath grant so the host wins the next tie
    logic                    src_dp;
    logic                    op_rd;
    logic [NUM_OQ_WIDTH-1:0] lat_q;
    logic [ADDR_WIDTH-1:0]   lat_a;
    logic [DATA_WIDTH-1:0]   lat_data;    // host write data or datapath delta
    logic [DATA_WIDTH-1:0]   rd_data;

    logic                    idx_ok;
    logic [IDX_W-1:0]        idx;
    logic                    wr_en;
    logic [DATA_WIDTH-1:0]   wr_data;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // Out-of-range queue or register indices map to nothing: reads give 0, writes are dropped.
    assign idx_ok = (int'(lat_q) < NUM_OUTPUT_QUEUES) && (int'(lat_a) < NUM_REGS_USED);
    assign idx    = IDX_W'(int'(lat_q) * NUM_REGS_USED + int'(lat_a));

    // Host reads never store; datapath stores the sum, wrapping modulo 2^DATA_WIDTH.
    assign wr_en   = (state == WR) && idx_ok && (src_dp || !op_rd);
    assign wr_data = src_dp ? (rd_data + lat_data) : lat_data;

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        grant_dp   = 1'b0;
        case (state)
            IDLE: begin
                if (dp_upd_req && !(prio_host && req_in_progress)) begin
                    grant      = 1'b1;
                    grant_dp   = 1'b1;
                    state_next = RD;
                end else if (req_in_progress) begin
                    grant      = 1'b1;
                    state_next = RD;
                end
            end
            RD:      state_next = WR;
            WR:      state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        result_ready = 1'b0;
        dp_upd_ack   = 1'b0;
        if (state == DONE) begin
            result_ready = !src_dp;
            dp_upd_ack   = src_dp;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            prio_host  <= 1'b0;
            src_dp     <= 1'b0;
            op_rd      <= 1'b0;
            lat_q      <= '0;
            lat_a      <= '0;
            lat_data   <= '0;
            rd_data    <= '0;
            reg_result <= '0;
        end else begin
            state <= state_next;
            if (grant) begin
                src_dp    <= grant_dp;
                prio_host <= grant_dp;
                if (grant_dp) begin
                    op_rd    <= 1'b0;
                    lat_q    <= dp_upd_q;
                    lat_a    <= dp_upd_addr;
                    lat_data <= dp_upd_delta;
                end else begin
                    op_rd    <= reg_rd_wr_L_held;
                    lat_q    <= q_addr;
                    lat_a    <= addr;
                    lat_data <= reg_data_held;
                end
            end
            if (state == RD) begin
                rd_data <= idx_ok ? mem[idx] : '0;
            end
            // Result is loaded leaving WR so it is valid during DONE and held afterwards.
            if (state == WR && !src_dp) begin
                reg_result <= op_rd ? rd_data : lat_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[idx] <= wr_data;
        end
    end

endmodule

// File: tb/tb_oq_regs_host_proc.sv
// tb/tb_oq_regs_host_proc.sv - directed self-checking bench for oq_regs_host_proc

module tb_oq_regs_host_proc;

    logic        clk;
    logic        reset_n;
    logic        req_in_progress;
    logic        reg_rd_wr_L_held;
    logic [31:0] reg_data_held;
    logic [4:0]  addr;
    logic [2:0]  q_addr;
    logic        result_ready;
    logic [31:0] reg_result;
    logic        dp_upd_req;
    logic [2:0]  dp_upd_q;
    logic [4:0]  dp_upd_addr;
    logic [31:0] dp_upd_delta;
    logic        dp_upd_ack;

    int tests_run    = 0;
    int tests_failed = 0;

    oq_regs_host_proc dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_in_progress  (req_in_progress),
        .reg_rd_wr_L_held (reg_rd_wr_L_held),
        .reg_data_held    (reg_data_held),
        .addr             (addr),
        .q_addr           (q_addr),
        .result_ready     (result_ready),
        .reg_result       (reg_result),
        .dp_upd_req       (dp_upd_req),
        .dp_upd_q         (dp_upd_q),
        .dp_upd_addr      (dp_upd_addr),
        .dp_upd_delta     (dp_upd_delta),
        .dp_upd_ack       (dp_upd_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Host access driver, called at a negedge. lat = negedges until result_ready (-1 on timeout),
    // extra = result_ready seen again on the following negedge, held = reg_result on that negedge.
    task automatic host_op(input logic rd, input logic [2:0] q, input logic [4:0] a,
                           input logic [31:0] d, output logic [31:0] res, output int lat,
                           output logic extra, output logic [31:0] held);
        req_in_progress  = 1'b1;
        reg_rd_wr_L_held = rd;
        q_addr           = q;
        addr             = a;
        reg_data_held    = d;
        lat = -1;
        res = 32'h0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (result_ready) begin
                lat = k;
                res = reg_result;
                break;
            end
        end
        req_in_progress = 1'b0;
        @(negedge clk);
        extra = result_ready;
        held  = reg_result;
    endtask

    task automatic dp_op(input logic [2:0] q, input logic [4:0] a, input logic [31:0] delta,
                         output int lat, output logic extra);
        dp_upd_req   = 1'b1;
        dp_upd_q     = q;
        dp_upd_addr  = a;
        dp_upd_delta = delta;
        lat = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (dp_upd_ack) begin
                lat = k;
                break;
            end
        end
        dp_upd_req = 1'b0;
        @(negedge clk);
        extra = dp_upd_ack;
    endtask

    task automatic test_reset;
        reset_n          = 1'b0;
        req_in_progress  = 1'b0;
        reg_rd_wr_L_held = 1'b1;
        reg_data_held    = 32'h0;
        addr             = 5'd0;
        q_addr           = 3'd0;
        dp_upd_req       = 1'b0;
        dp_upd_q         = 3'd0;
        dp_upd_addr      = 5'd0;
        dp_upd_delta     = 32'h0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (result_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_result_ready: got %b expected 0", result_ready);
        end
        tests_run++;
        if (dp_upd_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_dp_upd_ack: got %b expected 0", dp_upd_ack);
        end
        tests_run++;
        if (reg_result !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_reg_result: got %h expected 00000000", reg_result);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_host_rw;
        logic [31:0] res, held;
        int lat;
        logic extra;
        host_op(1'b0, 3'd3, 5'd5, 32'h1234_5678, res, lat, extra, held);
        tests_run++;
        if (lat !== 3) begin
            tests_failed++;
            $display("FAIL host_wr_latency: got %0d expected 3", lat);
        end
        tests_run++;
        if (res !== 32'h1234_5678) begin
            tests_failed++;
            $display("FAIL host_wr_echo: got %h expected 12345678", res);
        end
        tests_run++;
        if (extra !== 1'b0) begin
            tests_failed++;
            $display("FAIL host_wr_single_pulse: got %b expected 0", extra);
        end
        host_op(1'b1, 3'd3, 5'd5, 32'h0, res, lat, extra, held);
        tests_run++;
        if (lat !== 3) begin
            tests_failed++;
            $display("FAIL host_rd_latency: got %0d expected 3", lat);
        end
        tests_run++;
        if (res !== 32'h1234_5678) begin
            tests_failed++;
            $display("FAIL host_rd_data: got %h expected 12345678", res);
        end
        tests_run++;
        if (held !== 32'h1234_5678) begin
            tests_failed++;
            $display("FAIL host_rd_held: got %h expected 12345678", held);
        end
    endtask

    task automatic test_dp_update;
        logic [31:0] res, held;
        logic [31:0] deltas [5];
        int lat;
        logic extra;
        deltas = '{32'd1, 32'd1, 32'd1, 32'd1, 32'hFFFF_FFFF};
        for (int i = 0; i < 5; i++) begin
            dp_op(3'd0, 5'd2, deltas[i], lat, extra);
            tests_run++;
            if (lat !== 3 || extra !== 1'b0) begin
                tests_failed++;
                $display("FAIL dp_ack_pulse[%0d]: got latency %0d extra %b expected 3 and 0", i, lat, extra);
            end
        end
        host_op(1'b1, 3'd0, 5'd2, 32'h0, res, lat, extra, held);
        tests_run++;
        if (res !== 32'd3) begin
            tests_failed++;
            $display("FAIL dp_accumulate: got %h expected 00000003", res);
        end
    endtask

    task automatic test_wrap;
        logic [31:0] res, held;
        int lat;
        logic extra;
        host_op(1'b0, 3'd1, 5'd7, 32'hFFFF_FFFF, res, lat, extra, held);
        dp_op(3'd1, 5'd7, 32'd2, lat, extra);
        host_op(1'b1, 3'd1, 5'd7, 32'h0, res, lat, extra, held);
        tests_run++;
        if (res !== 32'h0000_0001) begin
            tests_failed++;
            $display("FAIL dp_wrap: got %h expected 00000001", res);
        end
    endtask

    task automatic test_arbitration;
        int dp_cyc, rr_cyc, acks;
        logic [31:0] res, held, host_res;
        int lat;
        logic extra;
        // Both requests rise together: datapath first, host 4 cycles later.
        dp_upd_req = 1'b1; dp_upd_q = 3'd0; dp_upd_addr = 5'd2; dp_upd_delta = 32'd5;
        req_in_progress = 1'b1; reg_rd_wr_L_held = 1'b1; q_addr = 3'd3; addr = 5'd5;
        dp_cyc = -1; rr_cyc = -1; host_res = 32'h0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (dp_upd_ack && dp_cyc < 0) begin
                dp_cyc = k;
                dp_upd_req = 1'b0;
            end
            if (result_ready && rr_cyc < 0) begin
                rr_cyc = k;
                host_res = reg_result;
                req_in_progress = 1'b0;
            end
            if (dp_cyc > 0 && rr_cyc > 0) break;
        end
        dp_upd_req = 1'b0;
        req_in_progress = 1'b0;
        @(negedge clk);
        tests_run++;
        if (dp_cyc !== 3) begin
            tests_failed++;
            $display("FAIL arb_dp_first: got ack at %0d expected 3", dp_cyc);
        end
        tests_run++;
        if (rr_cyc !== 7) begin
            tests_failed++;
            $display("FAIL arb_host_second: got result_ready at %0d expected 7", rr_cyc);
        end
        tests_run++;
        if (host_res !== 32'h1234_5678) begin
            tests_failed++;
            $display("FAIL arb_host_data: got %h expected 12345678", host_res);
        end
        host_op(1'b1, 3'd0, 5'd2, 32'h0, res, lat, extra, held);
        tests_run++;
        if (res !== 32'd8) begin
            tests_failed++;
            $display("FAIL arb_dp_applied: got %h expected 00000008", res);
        end

        // Continuous datapath stream: host raised mid-stream must still complete within 8 cycles.
        dp_upd_req = 1'b1; dp_upd_q = 3'd0; dp_upd_addr = 5'd4; dp_upd_delta = 32'd1;
        acks = 0; rr_cyc = -1;
        repeat (2) begin
            @(negedge clk);
            if (dp_upd_ack) acks++;
        end
        req_in_progress = 1'b1; reg_rd_wr_L_held = 1'b1; q_addr = 3'd3; addr = 5'd5;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (dp_upd_ack) acks++;
            if (result_ready) begin
                rr_cyc = k;
                req_in_progress = 1'b0;
                break;
            end
        end
        req_in_progress = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (dp_upd_ack) begin
                acks++;
                dp_upd_req = 1'b0;
                break;
            end
        end
        dp_upd_req = 1'b0;
        @(negedge clk);
        tests_run++;
        if (rr_cyc < 1 || rr_cyc > 8) begin
            tests_failed++;
            $display("FAIL no_starvation: got result_ready at %0d expected 1..8", rr_cyc);
        end
        host_op(1'b1, 3'd0, 5'd4, 32'h0, res, lat, extra, held);
        tests_run++;
        if (acks < 2 || res !== 32'(acks)) begin
            tests_failed++;
            $display("FAIL stream_count: got %h expected %h (at least 2)", res, 32'(acks));
        end
    endtask

    task automatic test_unused;
        logic [31:0] res, held;
        int lat;
        logic extra;
        int bad;
        host_op(1'b0, 3'd2, 5'd0, 32'h0000_A5A5, res, lat, extra, held);
        host_op(1'b1, 3'd2, 5'd19, 32'h0, res, lat, extra, held);
        tests_run++;
        if (res !== 32'h0 || lat !== 3) begin
            tests_failed++;
            $display("FAIL unused_read: got %h latency %0d expected 00000000 and 3", res, lat);
        end
        host_op(1'b0, 3'd2, 5'd19, 32'hDEAD_BEEF, res, lat, extra, held);
        tests_run++;
        if (res !== 32'hDEAD_BEEF || lat !== 3) begin
            tests_failed++;
            $display("FAIL unused_write_echo: got %h latency %0d expected deadbeef and 3", res, lat);
        end
        host_op(1'b1, 3'd2, 5'd19, 32'h0, res, lat, extra, held);
        tests_run++;
        if (res !== 32'h0) begin
            tests_failed++;
            $display("FAIL unused_read_after_write: got %h expected 00000000", res);
        end
        bad = 0;
        for (int a = 0; a < 19; a++) begin
            host_op(1'b1, 3'd2, 5'(a), 32'h0, res, lat, extra, held);
            if (res !== ((a == 0) ? 32'h0000_A5A5 : 32'h0)) begin
                bad++;
                $display("FAIL unused_no_alias[%0d]: got %h expected %h", a, res,
                         (a == 0) ? 32'h0000_A5A5 : 32'h0);
            end
        end
        tests_run++;
        if (bad != 0) tests_failed++;
    endtask

    task automatic test_reset_midflight;
        int rr_cyc;
        logic seen_rr;
        logic [31:0] res, held;
        int lat;
        logic extra;
        req_in_progress = 1'b1; reg_rd_wr_L_held = 1'b0; q_addr = 3'd5; addr = 5'd1;
        reg_data_held = 32'hCAFE_F00D;
        seen_rr = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (result_ready) seen_rr = 1'b1;
        end
        // FSM is in WR here.
        reset_n = 1'b0;
        #1;
        if (result_ready) seen_rr = 1'b1;
        @(negedge clk);
        if (result_ready) seen_rr = 1'b1;
        reset_n = 1'b1;
        tests_run++;
        if (seen_rr !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_abort_no_ready: got %b expected 0", seen_rr);
        end
        rr_cyc = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (result_ready) begin
                rr_cyc = k;
                req_in_progress = 1'b0;
                break;
            end
        end
        req_in_progress = 1'b0;
        @(negedge clk);
        tests_run++;
        if (rr_cyc !== 3) begin
            tests_failed++;
            $display("FAIL reset_retry_latency: got %0d expected 3", rr_cyc);
        end
        host_op(1'b1, 3'd5, 5'd1, 32'h0, res, lat, extra, held);
        tests_run++;
        if (res !== 32'hCAFE_F00D) begin
            tests_failed++;
            $display("FAIL reset_retry_data: got %h expected cafef00d", res);
        end
        host_op(1'b1, 3'd3, 5'd5, 32'h0, res, lat, extra, held);
        tests_run++;
        if (res !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_clears_storage: got %h expected 00000000", res);
        end
    endtask

    initial begin
        test_reset();
        test_host_rw();
        test_dp_update();
        test_wrap();
        test_arbitration();
        test_unused();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
